odu_err_inject: RTL and testbench
=================================

ODU_ERR_INJECT -- requirements
Module: odu_err_inject

Interface
REQ-001 Parameter DATA_W, default 384, ODU data bus width in bits.
REQ-002 Parameter MFAS_W, default 8, MFAS field width.
REQ-003 Parameter CNT_W, default 16, width of the period and injection counters.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 i_valid / i_data / i_fs / i_rs / i_mfas  in  1/DATA_W/1/1/MFAS_W  upstream ODU stream from the generator.
REQ-007 cfg_type  in  5  error-type enables: bit0 data, bit1 valid drop, bit2 fs invert, bit3 rs invert, bit4 mfas zero.
REQ-008 cfg_mode  in  2  00 off, 01 single-shot, 10 periodic, 11 continuous.
REQ-009 cfg_period  in  CNT_W  frames between periodic injections; 0 is treated as 1.
REQ-010 cfg_data_mask  in  DATA_W  XOR mask applied to data on an injected beat.
REQ-011 start  in  1  one-cycle pulse that arms injection.
REQ-012 cnt_clr  in  1  synchronous clear of o_inj_cnt.
REQ-013 o_valid / o_data / o_fs / o_rs / o_mfas  out  1/DATA_W/1/1/MFAS_W  downstream stream to the checker.
REQ-014 o_inj  out  1  high on the output beat that carries an injected error.
REQ-015 o_inj_cnt  out  CNT_W  saturating count of injected beats.
REQ-016 o_busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-017 All stream outputs shall be registered, with a fixed latency of 1 cycle from input to output on every cycle, whether or not i_valid is high.
REQ-018 A trigger beat is a cycle with i_valid=1 and i_fs=1; injection occurs only on trigger beats.
REQ-019 The FSM has three states: IDLE, ARMED and WAIT.
REQ-020 IDLE: start=1 with cfg_mode!=00 moves the FSM to ARMED; start in any other state is ignored.
REQ-021 ARMED: the next trigger beat is injected, then the FSM moves on by mode: 01 to IDLE; 10 to WAIT with the frame counter loaded with max(cfg_period,1)-1; 11 stays in ARMED.
REQ-022 WAIT: each trigger beat with counter!=0 decrements the counter with no injection; a trigger beat with counter==0 is injected and reloads the counter.
REQ-023 Periodic mode with cfg_period=0 or 1 injects every frame.
REQ-024 cfg_mode=00 in any state forces IDLE on the next edge and suppresses injection on the current beat.
REQ-025 Injected beat, per enabled cfg_type bit:
- o_data = i_data XOR cfg_data_mask.
- o_valid = 0.
- o_fs = ~i_fs.
- o_rs = ~i_rs.
- o_mfas = 0.
REQ-026 Disabled error types pass through unchanged; with cfg_type=0, o_inj still pulses but the stream is unmodified.
REQ-027 A non-injected beat is a bit-exact 1-cycle delay of the input.
REQ-028 o_inj_cnt increments by 1 per injected beat and saturates at 2^CNT_W-1.
REQ-029 cnt_clr and an injection in the same cycle set o_inj_cnt to 1.
REQ-030 cfg_* inputs are sampled every cycle; a cfg_period change takes effect at the next reload.

Reset
REQ-031 rst low asynchronously sets the FSM to IDLE and clears the frame counter, o_valid, o_fs, o_rs, o_data, o_mfas, o_inj, o_inj_cnt and o_busy.
REQ-032 Reset asserted mid-frame or mid-period discards any armed state; no injection occurs until a new start pulse.
REQ-033 Reset deassertion is synchronised to clk by the system; the block needs no internal synchroniser.

Structure
REQ-034 Package odu_pkg holds:
- cfg_type bit indices;
- cfg_mode encodings;
- the FSM state enum;
- default DATA_W/MFAS_W.
REQ-035 Sub-module odu_err_sched holds the FSM and frame counter and outputs a per-beat inject strobe.
REQ-036 The top level holds the masking datapath, output registers and the injection counter.

Verification
REQ-037 Pass-through: mode 00, 10 frames of counting data -> output equals input delayed 1 cycle; o_inj never high; o_inj_cnt=0.
REQ-038 Single-shot with cfg_type=5'b00001, mask=1, start -> only the first trigger beat has o_data[0] inverted; o_inj_cnt=1; o_busy falls after that beat.
REQ-039 Periodic with cfg_period=3, cfg_type=5'b00100, 12 frames -> o_fs inverted on frames 1, 4, 7 and 10; o_inj_cnt=4.
REQ-040 Continuous with cfg_type=5'b10010, 5 frames -> o_valid=0 and o_mfas=0 on all 5 trigger beats; o_inj_cnt=5.
REQ-041 Boundaries: with CNT_W=4, continuous for 20 frames -> o_inj_cnt saturates at 15; cnt_clr coinciding with an injection -> o_inj_cnt=1.
REQ-042 Reset in WAIT with 2 frames remaining -> all outputs 0 and o_busy=0; the following frames pass clean until a new start pulse.

Source files
------------

// File: rtl/odu_pkg.sv
// Shared definitions for the ODU error injector: error-type bit positions,
// mode encodings, scheduler states and default bus widths.
package odu_pkg;

  localparam int DATA_W_DEF = 384;
  localparam int MFAS_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Bit positions inside cfg_type
  localparam int TYPE_DATA  = 0;
  localparam int TYPE_VALID = 1;
  localparam int TYPE_FS    = 2;
  localparam int TYPE_RS    = 3;
  localparam int TYPE_MFAS  = 4;

  // cfg_mode encodings
  localparam logic [1:0] MODE_OFF      = 2'b00;
  localparam logic [1:0] MODE_SINGLE   = 2'b01;
  localparam logic [1:0] MODE_PERIODIC = 2'b10;
  localparam logic [1:0] MODE_CONT     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/odu_err_sched.sv
// Injection scheduler: decides on which trigger beat (valid frame start)
// an error is injected, based on the configured mode and frame period.
module odu_err_sched
  import odu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_fs,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             start,
  output logic             inject,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [CNT_W-1:0] reload;
  logic             trigger;

  assign trigger = i_valid & i_fs;
  // A period of 0 behaves like 1, so both reload to 0 (inject every frame).
  assign reload  = (cfg_period == '0) ? '0 : cfg_period - CNT_W'(1);
  assign busy    = (state != ST_IDLE);

  // State and frame-counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  // Next-state, counter update and per-beat inject strobe.
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    inject        = 1'b0;
    if (cfg_mode == MODE_OFF) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (trigger) begin
            inject = 1'b1;
            case (cfg_mode)
              MODE_SINGLE:   state_nxt = ST_IDLE;
              MODE_PERIODIC: begin
                state_nxt     = ST_WAIT;
                frame_cnt_nxt = reload;
              end
              default:       state_nxt = ST_ARMED;
            endcase
          end
        end
        ST_WAIT: begin
          if (trigger) begin
            if (frame_cnt != '0) begin
              frame_cnt_nxt = frame_cnt - CNT_W'(1);
            end else begin
              inject = 1'b1;
              case (cfg_mode)
                MODE_SINGLE:   state_nxt = ST_IDLE;
                MODE_PERIODIC: frame_cnt_nxt = reload;
                default:       state_nxt = ST_ARMED;
              endcase
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/odu_err_inject.sv
// ODU error injector: delays the upstream stream by one register stage and,
// on beats chosen by the scheduler, corrupts the enabled fields.
module odu_err_inject
  import odu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MFAS_W = MFAS_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_fs,
  input  logic              i_rs,
  input  logic [MFAS_W-1:0] i_mfas,
  input  logic [4:0]        cfg_type,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [DATA_W-1:0] cfg_data_mask,
  input  logic              start,
  input  logic              cnt_clr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_fs,
  output logic              o_rs,
  output logic [MFAS_W-1:0] o_mfas,
  output logic              o_inj,
  output logic [CNT_W-1:0]  o_inj_cnt,
  output logic              o_busy
);

  logic              inject;
  logic              valid_nxt, fs_nxt, rs_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [MFAS_W-1:0] mfas_nxt;

  odu_err_sched #(.CNT_W(CNT_W)) u_sched (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_fs       (i_fs),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .start      (start),
    .inject     (inject),
    .busy       (o_busy)
  );

  // Masking datapath: corrupt only the fields whose type bit is enabled.
  always_comb begin
    valid_nxt = i_valid;
    data_nxt  = i_data;
    fs_nxt    = i_fs;
    rs_nxt    = i_rs;
    mfas_nxt  = i_mfas;
    if (inject) begin
      if (cfg_type[TYPE_DATA])  data_nxt  = i_data ^ cfg_data_mask;
      if (cfg_type[TYPE_VALID]) valid_nxt = 1'b0;
      if (cfg_type[TYPE_FS])    fs_nxt    = ~i_fs;
      if (cfg_type[TYPE_RS])    rs_nxt    = ~i_rs;
      if (cfg_type[TYPE_MFAS])  mfas_nxt  = '0;
    end
  end

  // Output stream registers: fixed one-cycle latency on every cycle.
  // NOTE: the wide data register is reset too, so the downstream checker
  // never sees stale bus contents straight after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_fs    <= 1'b0;
      o_rs    <= 1'b0;
      o_mfas  <= '0;
      o_inj   <= 1'b0;
    end else begin
      o_valid <= valid_nxt;
      o_data  <= data_nxt;
      o_fs    <= fs_nxt;
      o_rs    <= rs_nxt;
      o_mfas  <= mfas_nxt;
      o_inj   <= inject;
    end
  end

  // Saturating injection counter; a clear coinciding with an injection
  // leaves exactly that one injection counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_inj_cnt <= '0;
    end else if (cnt_clr) begin
      o_inj_cnt <= inject ? CNT_W'(1) : '0;
    end else if (inject && (o_inj_cnt != '1)) begin
      o_inj_cnt <= o_inj_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_odu_err_inject.sv
// Directed self-checking bench for odu_err_inject. Frames are FL beats long:
// beat 0 carries fs (the trigger), beat 1 carries rs, the last beat is idle.
module tb_odu_err_inject;

  localparam int DATA_W = 384;
  localparam int MFAS_W = 8;
  localparam int CNT_W  = 4;
  localparam int FL     = 4;

  typedef struct packed {
    logic              v;
    logic              fs;
    logic              rs;
    logic [MFAS_W-1:0] mfas;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk, rst;
  logic              i_valid, i_fs, i_rs;
  logic [DATA_W-1:0] i_data;
  logic [MFAS_W-1:0] i_mfas;
  logic [4:0]        cfg_type;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_period;
  logic [DATA_W-1:0] cfg_data_mask;
  logic              start, cnt_clr;
  logic              o_valid, o_fs, o_rs, o_inj, o_busy;
  logic [DATA_W-1:0] o_data;
  logic [MFAS_W-1:0] o_mfas;
  logic [CNT_W-1:0]  o_inj_cnt;
  beat_t             obs;

  int n_cmp = 0;
  int n_bad = 0;

  odu_err_inject #(.DATA_W(DATA_W), .MFAS_W(MFAS_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .i_fs          (i_fs),
    .i_rs          (i_rs),
    .i_mfas        (i_mfas),
    .cfg_type      (cfg_type),
    .cfg_mode      (cfg_mode),
    .cfg_period    (cfg_period),
    .cfg_data_mask (cfg_data_mask),
    .start         (start),
    .cnt_clr       (cnt_clr),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .o_fs          (o_fs),
    .o_rs          (o_rs),
    .o_mfas        (o_mfas),
    .o_inj         (o_inj),
    .o_inj_cnt     (o_inj_cnt),
    .o_busy        (o_busy)
  );

  assign obs = {o_valid, o_fs, o_rs, o_mfas, o_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat b of frame f: counting data replicated across the bus.
  function automatic beat_t mk_beat(input int f, input int b);
    beat_t x;
    x.v    = (b != FL - 1);
    x.fs   = (b == 0);
    x.rs   = (b == 1);
    x.mfas = MFAS_W'(f + 1);
    x.data = {(DATA_W / 32){32'(f * FL + b + 1) ^ 32'h5A00_0000}};
    return x;
  endfunction

  // Expected output of an injected beat for a given type set and mask.
  function automatic beat_t corrupt(input beat_t x, input logic [4:0] t,
                                    input logic [DATA_W-1:0] m);
    beat_t y;
    y = x;
    if (t[0]) y.data = x.data ^ m;
    if (t[1]) y.v    = 1'b0;
    if (t[2]) y.fs   = ~x.fs;
    if (t[3]) y.rs   = ~x.rs;
    if (t[4]) y.mfas = '0;
    return y;
  endfunction

  // Apply one beat, clock it, and settle just after the edge.
  task automatic drive(input beat_t x);
    i_valid = x.v;
    i_fs    = x.fs;
    i_rs    = x.rs;
    i_mfas  = x.mfas;
    i_data  = x.data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_beat();
    beat_t z;
    z = '0;
    drive(z);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle_beat();
    start = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    idle_beat();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    beat_t x;
    rst = 1'b0;
    cfg_mode = 2'b11;
    start = 1'b1;
    x = mk_beat(0, 0);
    drive(x);
    drive(x);
    start = 1'b0;
    n_cmp++;
    if (obs !== beat_t'('0)) begin
      n_bad++;
      $display("FAIL reset_stream: got %h expected 0", obs);
    end
    n_cmp++;
    if ({o_inj, o_busy, o_inj_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got inj=%b busy=%b cnt=%0d expected 0/0/0", o_inj, o_busy, o_inj_cnt);
    end
    rst = 1'b1;
    idle_beat();
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_start_ignored: busy got %b expected 0", o_busy);
    end
    cfg_mode = 2'b00;
    idle_beat();
  endtask

  task automatic test_passthrough();
    beat_t x;
    cfg_mode = 2'b00;
    cfg_type = 5'h1F;
    cfg_data_mask = '1;
    pulse_start();
    for (int f = 0; f < 10; f++) begin
      for (int b = 0; b < FL; b++) begin
        x = mk_beat(f, b);
        drive(x);
        n_cmp++;
        if (obs !== x || o_inj !== 1'b0) begin
          n_bad++;
          $display("FAIL pass f%0d b%0d: got %h inj=%b expected %h inj=0", f, b, obs, o_inj, x);
        end
      end
    end
    n_cmp++;
    if (o_inj_cnt !== '0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL pass_end: cnt=%0d busy=%b expected 0/0", o_inj_cnt, o_busy);
    end
  endtask

  task automatic test_single();
    beat_t x, e;
    logic inj;
    cfg_mode = 2'b01;
    cfg_type = 5'b00001;
    cfg_data_mask = DATA_W'(1);
    clear_cnt();
    pulse_start();
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_armed: busy got %b expected 1", o_busy);
    end
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < FL; b++) begin
        x = mk_beat(f, b);
        drive(x);
        inj = (f == 0 && b == 0);
        e = inj ? corrupt(x, cfg_type, cfg_data_mask) : x;
        n_cmp++;
        if (obs !== e || o_inj !== inj) begin
          n_bad++;
          $display("FAIL single f%0d b%0d: got %h inj=%b expected %h inj=%b", f, b, obs, o_inj, e, inj);
        end
        if (inj) begin
          n_cmp++;
          if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy_fall: busy got %b expected 0", o_busy);
          end
        end
      end
    end
    n_cmp++;
    if (o_inj_cnt !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL single_cnt: got %0d expected 1", o_inj_cnt);
    end
    cfg_mode = 2'b00;
    idle_beat();
  endtask

  task automatic test_periodic();
    beat_t x, e;
    logic inj;
    cfg_mode = 2'b10;
    cfg_period = CNT_W'(3);
    cfg_type = 5'b00100;
    cfg_data_mask = '1;
    clear_cnt();
    pulse_start();
    for (int f = 0; f < 12; f++) begin
      for (int b = 0; b < FL; b++) begin
        x = mk_beat(f, b);
        drive(x);
        inj = (b == 0) && (f % 3 == 0);
        e = inj ? corrupt(x, cfg_type, cfg_data_mask) : x;
        n_cmp++;
        if (obs !== e || o_inj !== inj) begin
          n_bad++;
          $display("FAIL periodic f%0d b%0d: got %h inj=%b expected %h inj=%b", f, b, obs, o_inj, e, inj);
        end
      end
    end
    n_cmp++;
    if (o_inj_cnt !== CNT_W'(4) || o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL periodic_end: cnt=%0d busy=%b expected 4/1", o_inj_cnt, o_busy);
    end
    cfg_mode = 2'b00;
    idle_beat();
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL periodic_off: busy got %b expected 0", o_busy);
    end
  endtask

  task automatic test_period_zero();
    beat_t x, e;
    logic inj;
    cfg_mode = 2'b10;
    cfg_period = '0;
    cfg_type = 5'b01000;
    clear_cnt();
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < FL; b++) begin
        x = mk_beat(f, b);
        drive(x);
        inj = (b == 0);
        e = inj ? corrupt(x, cfg_type, cfg_data_mask) : x;
        n_cmp++;
        if (obs !== e || o_inj !== inj) begin
          n_bad++;
          $display("FAIL period0 f%0d b%0d: got %h inj=%b expected %h inj=%b", f, b, obs, o_inj, e, inj);
        end
      end
    end
    n_cmp++;
    if (o_inj_cnt !== CNT_W'(3)) begin
      n_bad++;
      $display("FAIL period0_cnt: got %0d expected 3", o_inj_cnt);
    end
    cfg_mode = 2'b00;
    idle_beat();
  endtask

  task automatic test_continuous();
    beat_t x, e;
    logic inj;
    cfg_mode = 2'b11;
    cfg_type = 5'b10010;
    clear_cnt();
    pulse_start();
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < FL; b++) begin
        x = mk_beat(f, b);
        drive(x);
        inj = (b == 0);
        e = inj ? corrupt(x, cfg_type, cfg_data_mask) : x;
        n_cmp++;
        if (obs !== e || o_inj !== inj) begin
          n_bad++;
          $display("FAIL cont f%0d b%0d: got %h inj=%b expected %h inj=%b", f, b, obs, o_inj, e, inj);
        end
      end
    end
    n_cmp++;
    if (o_inj_cnt !== CNT_W'(5)) begin
      n_bad++;
      $display("FAIL cont_cnt: got %0d expected 5", o_inj_cnt);
    end
    cfg_mode = 2'b00;
    idle_beat();
  endtask

  task automatic test_saturation();
    beat_t x;
    logic inj;
    int exp_cnt;
    cfg_mode = 2'b11;
    cfg_type = 5'b00000;
    clear_cnt();
    pulse_start();
    for (int f = 0; f < 20; f++) begin
      for (int b = 0; b < FL; b++) begin
        x = mk_beat(f, b);
        drive(x);
        inj = (b == 0);
        n_cmp++;
        if (obs !== x || o_inj !== inj) begin
          n_bad++;
          $display("FAIL sat_stream f%0d b%0d: got %h inj=%b expected %h inj=%b", f, b, obs, o_inj, x, inj);
        end
      end
      exp_cnt = (f + 1 > 15) ? 15 : f + 1;
      n_cmp++;
      if (o_inj_cnt !== CNT_W'(exp_cnt)) begin
        n_bad++;
        $display("FAIL sat_cnt f%0d: got %0d expected %0d", f, o_inj_cnt, exp_cnt);
      end
    end
    cnt_clr = 1'b1;
    x = mk_beat(20, 0);
    drive(x);
    cnt_clr = 1'b0;
    n_cmp++;
    if (o_inj !== 1'b1 || o_inj_cnt !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL clr_with_inj: inj=%b cnt=%0d expected 1/1", o_inj, o_inj_cnt);
    end
    cfg_mode = 2'b00;
    idle_beat();
  endtask

  task automatic test_reset_wait();
    beat_t x, e;
    logic inj;
    cfg_mode = 2'b10;
    cfg_period = CNT_W'(4);
    cfg_type = 5'b00001;
    cfg_data_mask = '1;
    clear_cnt();
    pulse_start();
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < FL; b++) begin
        x = mk_beat(f, b);
        drive(x);
        inj = (f == 0 && b == 0);
        e = inj ? corrupt(x, cfg_type, cfg_data_mask) : x;
        n_cmp++;
        if (obs !== e || o_inj !== inj) begin
          n_bad++;
          $display("FAIL rstwait_pre f%0d b%0d: got %h inj=%b expected %h inj=%b", f, b, obs, o_inj, e, inj);
        end
      end
    end
    // Two frames remain before the next periodic injection.
    x = mk_beat(2, 0);
    i_valid = x.v;
    i_fs    = x.fs;
    i_rs    = x.rs;
    i_mfas  = x.mfas;
    i_data  = x.data;
    rst = 1'b0;
    #2;
    n_cmp++;
    if (obs !== beat_t'('0) || {o_inj, o_busy, o_inj_cnt} !== '0) begin
      n_bad++;
      $display("FAIL rstwait_async: got %h inj=%b busy=%b cnt=%0d expected all 0", obs, o_inj, o_busy, o_inj_cnt);
    end
    #1;
    rst = 1'b1;
    for (int f = 2; f < 8; f++) begin
      for (int b = 0; b < FL; b++) begin
        x = mk_beat(f, b);
        drive(x);
        n_cmp++;
        if (obs !== x || o_inj !== 1'b0) begin
          n_bad++;
          $display("FAIL rstwait_post f%0d b%0d: got %h inj=%b expected %h inj=0", f, b, obs, o_inj, x);
        end
      end
    end
    n_cmp++;
    if (o_busy !== 1'b0 || o_inj_cnt !== '0) begin
      n_bad++;
      $display("FAIL rstwait_end: busy=%b cnt=%0d expected 0/0", o_busy, o_inj_cnt);
    end
    cfg_mode = 2'b00;
    idle_beat();
  endtask

  initial begin
    rst = 1'b0;
    i_valid = 1'b0;
    i_fs = 1'b0;
    i_rs = 1'b0;
    i_data = '0;
    i_mfas = '0;
    cfg_type = '0;
    cfg_mode = 2'b00;
    cfg_period = '0;
    cfg_data_mask = '0;
    start = 1'b0;
    cnt_clr = 1'b0;

    test_reset();
    test_passthrough();
    test_single();
    test_periodic();
    test_period_zero();
    test_continuous();
    test_saturation();
    test_reset_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
